eq_biquad_scheduler: RTL and testbench



---
 rtl/eq_biquad_scheduler_if.sv | 25 ++
 rtl/eq_biquad_scheduler.sv | 178 +++++++++++++++++
 tb/tb_eq_biquad_scheduler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_biquad_scheduler_if.sv
// Sample handshake and band-output bundle for the time-multiplexed biquad equalizer.
// The master side drives samples; the slave side is the scheduler.
interface eq_biquad_scheduler_if #(
    parameter int Width = 23
);
    logic             enable;
    logic [Width-1:0] uk;
    logic             sample_valid;
    logic             busy;
    logic             sample_dropped;
    logic             out_valid;
    logic [Width-1:0] yk_HPBass;
    logic [Width-1:0] yk_HPMed;
    logic [Width-1:0] yk_HPHigh;

    modport master (
        output enable, uk, sample_valid,
        input  busy, sample_dropped, out_valid, yk_HPBass, yk_HPMed, yk_HPHigh
    );

    modport slave (
        input  enable, uk, sample_valid,
        output busy, sample_dropped, out_valid, yk_HPBass, yk_HPMed, yk_HPHigh
    );
endinterface

// File: rtl/eq_biquad_scheduler.sv
// Six-section three-band biquad cascade sharing one multiplier and one accumulator.
// Each sample costs 5 MAC cycles plus 1 write-back cycle per section: 36 cycles total.
module eq_biquad_scheduler #(
    parameter int p     = 8,
    parameter int f     = 14,
    parameter int Width = p + f + 1
) (
    input  logic                 sclk,
    input  logic                 rst,
    eq_biquad_scheduler_if.slave bus
);
    localparam int AccW = 2 * Width + 2;
    localparam int NSec = 6;
    localparam int NTap = 5;

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    // Rows are sections, columns are {b0, b1, b2, a1, a2}; a-terms already carry their sign.
    localparam logic signed [Width-1:0] COEF [NSec][NTap] = '{
        '{23'h000003, 23'h000007, 23'h000003, 23'h007d71, 23'h7fc287},
        '{23'h003fdf, 23'h7f8042, 23'h003fdf, 23'h007fbe, 23'h7fc042},
        '{23'h000552, 23'h000110, 23'h000552, 23'h00423d, 23'h7fe876},
        '{23'h004000, 23'h7f8000, 23'h004000, 23'h007d71, 23'h7fc287},
        '{23'h00340b, 23'h006810, 23'h00340b, 23'h7f9a2d, 23'h7fd5a7},
        '{23'h002672, 23'h004cdd, 23'h002672, 23'h00423d, 23'h7fe876}
    };

    state_t                  state_q, state_d;
    logic [2:0]              sec_q, sec_d;
    logic [2:0]              tap_q, tap_d;
    logic signed [AccW-1:0]  acc_q, acc_d;
    logic signed [Width-1:0] x_in_q, x_in_d;
    logic signed [Width-1:0] x1_q [NSec];
    logic signed [Width-1:0] x1_d [NSec];
    logic signed [Width-1:0] x2_q [NSec];
    logic signed [Width-1:0] x2_d [NSec];
    logic signed [Width-1:0] y1_q [NSec];
    logic signed [Width-1:0] y1_d [NSec];
    logic signed [Width-1:0] y2_q [NSec];
    logic signed [Width-1:0] y2_d [NSec];
    logic [Width-1:0]        bass_q, bass_d;
    logic [Width-1:0]        med_q, med_d;
    logic [Width-1:0]        high_q, high_d;
    logic                    out_valid_q, out_valid_d;
    logic                    dropped_q, dropped_d;

    logic signed [Width-1:0]   sec_x;
    logic signed [Width-1:0]   op_sel;
    logic signed [Width-1:0]   coef_sel;
    logic signed [2*Width-1:0] prod;
    logic signed [Width-1:0]   y_sat;

    // Odd sections are the high-pass half of a band and take the low-pass result just written.
    assign sec_x    = sec_q[0] ? y1_q[sec_q - 3'd1] : x_in_q;
    assign coef_sel = COEF[sec_q][tap_q];
    assign prod     = coef_sel * op_sel;

    always_comb begin
        op_sel = sec_x;
        case (tap_q)
            3'd1:    op_sel = x1_q[sec_q];
            3'd2:    op_sel = x2_q[sec_q];
            3'd3:    op_sel = y1_q[sec_q];
            3'd4:    op_sel = y2_q[sec_q];
            default: op_sel = sec_x;
        endcase
    end

    // acc >>> f fits Width exactly when every bit above the result's sign bit matches it.
    always_comb begin
        if ((&acc_q[AccW-1:f+Width-1]) || !(|acc_q[AccW-1:f+Width-1])) begin
            y_sat = acc_q[f+Width-1:f];
        end else if (acc_q[AccW-1]) begin
            y_sat = {1'b1, {(Width-1){1'b0}}};
        end else begin
            y_sat = {1'b0, {(Width-1){1'b1}}};
        end
    end

    always_comb begin
        // NOTE: every next-state value takes its hold value first, so no path can infer a latch.
        state_d     = state_q;
        sec_d       = sec_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        x_in_d      = x_in_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        bass_d      = bass_q;
        med_d       = med_q;
        high_d      = high_q;
        out_valid_d = 1'b0;
        dropped_d   = bus.sample_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.sample_valid && bus.enable) begin
                    x_in_d  = bus.uk;
                    sec_d   = 3'd0;
                    tap_d   = 3'd0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + AccW'(prod);
                if (tap_q == 3'd4) begin
                    state_d = WRITE;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            WRITE: begin
                x2_d[sec_q] = x1_q[sec_q];
                x1_d[sec_q] = sec_x;
                y2_d[sec_q] = y1_q[sec_q];
                y1_d[sec_q] = y_sat;
                acc_d       = '0;
                tap_d       = 3'd0;
                if (sec_q == 3'd5) begin
                    bass_d      = y1_q[1];
                    med_d       = y1_q[3];
                    high_d      = y_sat;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    sec_d   = sec_q + 3'd1;
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= IDLE;
            sec_q       <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            x_in_q      <= '0;
            // NOTE: the filter history is cleared on reset so a restarted stream behaves identically.
            x1_q        <= '{default: '0};
            x2_q        <= '{default: '0};
            y1_q        <= '{default: '0};
            y2_q        <= '{default: '0};
            bass_q      <= '0;
            med_q       <= '0;
            high_q      <= '0;
            out_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            x_in_q      <= x_in_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            bass_q      <= bass_d;
            med_q       <= med_d;
            high_q      <= high_d;
            out_valid_q <= out_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    assign bus.busy           = (state_q != IDLE);
    assign bus.sample_dropped = dropped_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.yk_HPBass      = bass_q;
    assign bus.yk_HPMed       = med_q;
    assign bus.yk_HPHigh      = high_q;
endmodule

// File: tb/tb_eq_biquad_scheduler.sv
// Scoreboard bench for eq_biquad_scheduler: a floor/saturate reference model predicts each
// frame when its sample is accepted; the monitor compares on every out_valid.
module tb_eq_biquad_scheduler;
    localparam int W = 23;

    localparam logic [W-1:0] MC [6][5] = '{
        '{23'h000003, 23'h000007, 23'h000003, 23'h007d71, 23'h7fc287},
        '{23'h003fdf, 23'h7f8042, 23'h003fdf, 23'h007fbe, 23'h7fc042},
        '{23'h000552, 23'h000110, 23'h000552, 23'h00423d, 23'h7fe876},
        '{23'h004000, 23'h7f8000, 23'h004000, 23'h007d71, 23'h7fc287},
        '{23'h00340b, 23'h006810, 23'h00340b, 23'h7f9a2d, 23'h7fd5a7},
        '{23'h002672, 23'h004cdd, 23'h002672, 23'h00423d, 23'h7fe876}
    };

    typedef struct {
        logic [W-1:0] bass;
        logic [W-1:0] med;
        logic [W-1:0] high;
        int           e0;
    } exp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   drop_cnt = 0;
    int   last_e0  = 0;
    exp_t sb [$];

    longint m_x1 [6];
    longint m_x2 [6];
    longint m_y1 [6];
    longint m_y2 [6];

    eq_biquad_scheduler_if #(.Width(W)) bus ();

    eq_biquad_scheduler dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint cf(input int s, input int t);
        return longint'($signed(MC[s][t]));
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 6; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
    endtask

    task automatic model_frame(input logic [W-1:0] u, output exp_t e);
        longint x, acc, q, prev;
        longint ys [6];
        prev = 0;
        for (int s = 0; s < 6; s++) begin
            x = (s % 2 == 0) ? longint'($signed(u)) : prev;
            acc = cf(s,0)*x + cf(s,1)*m_x1[s] + cf(s,2)*m_x2[s] + cf(s,3)*m_y1[s] + cf(s,4)*m_y2[s];
            q = acc >>> 14;
            if (q > 64'sd4194303)  q = 64'sd4194303;
            if (q < -64'sd4194304) q = -64'sd4194304;
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = q;
            ys[s] = q;
            prev = q;
        end
        e.bass = W'(ys[1]);
        e.med  = W'(ys[3]);
        e.high = W'(ys[5]);
        e.e0   = 0;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge sclk) begin
        if (!rst && bus.sample_dropped) drop_cnt++;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency",  cyc - e.e0, 36);
                check("yk_HPBass", bus.yk_HPBass, e.bass);
                check("yk_HPMed",  bus.yk_HPMed,  e.med);
                check("yk_HPHigh", bus.yk_HPHigh, e.high);
            end
        end
    end

    task automatic send(input logic [W-1:0] u);
        exp_t e;
        int n;
        n = 0;
        @(negedge sclk);
        while (bus.busy) begin
            n++;
            if (n > 100) begin
                check("send_wait_timeout", 1, 0);
                return;
            end
            @(negedge sclk);
        end
        bus.uk = u;
        bus.sample_valid = 1'b1;
        model_frame(u, e);
        @(posedge sclk);
        #1;
        e.e0 = cyc;
        last_e0 = cyc;
        sb.push_back(e);
        bus.sample_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 || bus.busy) begin
            @(negedge sclk);
            n++;
            if (n > 1000) begin
                check("drain_timeout", sb.size(), 0);
                return;
            end
        end
    endtask

    task automatic goto_neg(input int c);
        do @(negedge sclk); while (cyc < c);
    endtask

    task automatic impulse_and_check(input string tag);
        send(23'h004000);
        drain();
        check({tag, "_bass"}, bus.yk_HPBass, 23'h000002);
        check({tag, "_med"},  bus.yk_HPMed,  23'h000552);
        check({tag, "_high"}, bus.yk_HPHigh, 23'h001F43);
    endtask

    initial begin
        int e0, d0;
        bus.enable = 1'b1;
        bus.uk = '0;
        bus.sample_valid = 1'b0;
        model_reset();

        repeat (3) @(negedge sclk);
        check("rst_busy",      bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dropped",   bus.sample_dropped, 0);
        check("rst_bass",      bus.yk_HPBass, 0);
        check("rst_med",       bus.yk_HPMed, 0);
        check("rst_high",      bus.yk_HPHigh, 0);
        rst = 1'b0;

        // Impulse response, then a tail of zeros.
        impulse_and_check("impulse");
        for (int i = 0; i < 20; i++) send(23'h000000);
        drain();

        // DC step at the minimum period; acceptance spacing must be exactly 37.
        d0 = drop_cnt;
        send(23'h004000);
        e0 = last_e0;
        send(23'h004000);
        check("period_37", last_e0 - e0, 37);
        for (int i = 0; i < 1998; i++) send(23'h004000);
        drain();
        check("dc_no_drop", drop_cnt - d0, 0);

        // Overrun: requests at E0+10 and E0+36 are dropped; E0+37 is accepted.
        d0 = drop_cnt;
        send(23'h001234);
        e0 = last_e0;
        goto_neg(e0 + 9);
        bus.uk = 23'h3FFFFF;
        bus.sample_valid = 1'b1;
        @(negedge sclk);
        check("drop_pulse_e10", bus.sample_dropped, 1);
        bus.sample_valid = 1'b0;
        bus.uk = '0;
        goto_neg(e0 + 35);
        bus.uk = 23'h3FFFFF;
        bus.sample_valid = 1'b1;
        send(23'h000800);
        check("accept_e37", last_e0 - e0, 37);
        drain();
        check("overrun_drops", drop_cnt - d0, 2);

        // Saturation: full-scale positive, then alternating full-scale swings.
        for (int i = 0; i < 12; i++) send(23'h3FFFFF);
        for (int i = 0; i < 12; i++) send((i % 2 == 0) ? 23'h3FFFFF : 23'h400000);
        for (int i = 0; i < 6; i++) send(23'h000000);
        drain();

        // Reset mid-frame clears everything; the next impulse matches the first exactly.
        send(23'h004000);
        e0 = last_e0;
        goto_neg(e0 + 19);
        rst = 1'b1;
        @(negedge sclk);
        sb.delete();
        model_reset();
        check("midrst_busy", bus.busy, 0);
        check("midrst_bass", bus.yk_HPBass, 0);
        check("midrst_med",  bus.yk_HPMed, 0);
        check("midrst_high", bus.yk_HPHigh, 0);
        rst = 1'b0;
        impulse_and_check("post_rst_impulse");

        // Enable gating: requests while disabled are ignored silently.
        d0 = drop_cnt;
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sclk);
            bus.uk = 23'h001000;
            bus.sample_valid = 1'b1;
            @(negedge sclk);
            bus.sample_valid = 1'b0;
            check("disabled_no_accept", bus.busy, 0);
        end
        check("disabled_no_drop", drop_cnt - d0, 0);
        bus.enable = 1'b1;

        // Dropping enable mid-frame lets the frame finish on time.
        send(23'h002000);
        e0 = last_e0;
        goto_neg(e0 + 4);
        bus.enable = 1'b0;
        drain();
        bus.enable = 1'b1;
        send(23'h000000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
